// File: rtl/heap_requester.sv
`default_nettype none
// ============================================================================
// Module      : heap_requester
// Description : Single-outstanding initiator for the heap Memory action bus.
//               Accepts a request, toggles heapClock once, waits a settle
//               time, returns heapOut/heapError, and tracks the first error.
// Revision    : 1.0 - initial release
// ============================================================================
module heap_requester #(
    parameter int ADDRESS_BITS  = 2,
    parameter int INDEX_BITS    = 1,
    parameter int DATA_BITS     = 12,
    parameter int SETTLE_CYCLES = 1,
    parameter int MAX_ACTION    = 30
) (
    input  logic                    clock,
    input  logic                    reset,

    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [7:0]              req_action,
    input  logic [ADDRESS_BITS-1:0] req_array,
    input  logic [INDEX_BITS-1:0]   req_index,
    input  logic [DATA_BITS-1:0]    req_in,

    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_BITS-1:0]    rsp_out,
    output logic [31:0]             rsp_error,

    output logic                    heapClock,
    output logic [7:0]              heapAction,
    output logic [ADDRESS_BITS-1:0] heapArray,
    output logic [INDEX_BITS-1:0]   heapIndex,
    output logic [DATA_BITS-1:0]    heapIn,
    input  logic [DATA_BITS-1:0]    heapOut,
    input  logic [31:0]             heapError,

    output logic [31:0]             op_count,
    output logic                    err_seen,
    output logic [31:0]             err_code,
    output logic [31:0]             err_op
);

    localparam logic [2:0] c_IDLE    = 3'd0;
    localparam logic [2:0] c_SETUP   = 3'd1;
    localparam logic [2:0] c_TOGGLE  = 3'd2;
    localparam logic [2:0] c_SETTLE  = 3'd3;
    localparam logic [2:0] c_RESPOND = 3'd4;

    localparam logic [3:0] c_SETTLE_LOAD = 4'(SETTLE_CYCLES);
    localparam logic [7:0] c_MAX_ACTION  = 8'(MAX_ACTION);

    logic [2:0]              r_state;
    logic [3:0]              r_settle_cnt;
    logic [DATA_BITS-1:0]    r_rsp_out;
    logic [31:0]             r_rsp_error;
    logic                    r_heap_clock;
    logic [7:0]              r_heap_action;
    logic [ADDRESS_BITS-1:0] r_heap_array;
    logic [INDEX_BITS-1:0]   r_heap_index;
    logic [DATA_BITS-1:0]    r_heap_in;
    logic [31:0]             r_op_count;
    logic                    r_err_seen;
    logic [31:0]             r_err_code;
    logic [31:0]             r_err_op;

    logic w_accept;
    logic w_legal;
    logic w_handshake;

    assign w_accept    = (r_state == c_IDLE) && req_valid;
    assign w_legal     = (req_action != 8'd0) && (req_action <= c_MAX_ACTION);
    assign w_handshake = (r_state == c_RESPOND) && rsp_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= c_IDLE;
            r_settle_cnt  <= 4'd0;
            r_rsp_out     <= '0;
            r_rsp_error   <= 32'd0;
            r_heap_clock  <= 1'b0;
            r_heap_action <= 8'd0;
            r_heap_array  <= '0;
            r_heap_index  <= '0;
            r_heap_in     <= '0;
            r_op_count    <= 32'd0;
            r_err_seen    <= 1'b0;
            r_err_code    <= 32'd0;
            r_err_op      <= 32'd0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_accept) begin
                        r_heap_array <= req_array;
                        r_heap_index <= req_index;
                        r_heap_in    <= req_in;
                        r_state      <= c_SETUP;
                        if (w_legal) begin
                            r_heap_action <= req_action;
                        end else begin
                            r_heap_action <= 8'd0;
                            r_rsp_out     <= '0;
                            r_rsp_error   <= 32'd1;
                        end
                    end
                end
                c_SETUP: begin
                    // Action 0 here can only come from a rejected request:
                    // its response is already loaded, so skip the toggle.
                    if (r_heap_action == 8'd0) begin
                        r_state <= c_RESPOND;
                    end else begin
                        r_state <= c_TOGGLE;
                    end
                end
                c_TOGGLE: begin
                    r_heap_clock <= ~r_heap_clock;
                    r_settle_cnt <= c_SETTLE_LOAD;
                    r_state      <= c_SETTLE;
                end
                c_SETTLE: begin
                    if (r_settle_cnt == 4'd1) begin
                        r_rsp_out   <= heapOut;
                        r_rsp_error <= heapError;
                        r_state     <= c_RESPOND;
                    end else begin
                        r_settle_cnt <= r_settle_cnt - 4'd1;
                    end
                end
                c_RESPOND: begin
                    if (w_handshake) begin
                        r_op_count <= r_op_count + 32'd1;
                        r_state    <= c_IDLE;
                        if ((r_rsp_error != 32'd0) && !r_err_seen) begin
                            r_err_seen <= 1'b1;
                            r_err_code <= r_rsp_error;
                            r_err_op   <= r_op_count;
                        end
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign req_ready  = (r_state == c_IDLE);
    assign rsp_valid  = (r_state == c_RESPOND);
    assign rsp_out    = r_rsp_out;
    assign rsp_error  = r_rsp_error;
    assign heapClock  = r_heap_clock;
    assign heapAction = r_heap_action;
    assign heapArray  = r_heap_array;
    assign heapIndex  = r_heap_index;
    assign heapIn     = r_heap_in;
    assign op_count   = r_op_count;
    assign err_seen   = r_err_seen;
    assign err_code   = r_err_code;
    assign err_op     = r_err_op;

endmodule
`default_nettype wire

// File: tb/tb_heap_requester.sv
`default_nettype none
// ============================================================================
// Module      : tb_heap_requester
// Description : Directed self-checking bench for heap_requester.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_heap_requester;

    logic        clock;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [7:0]  req_action;
    logic [1:0]  req_array;
    logic [0:0]  req_index;
    logic [11:0] req_in;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [11:0] rsp_out;
    logic [31:0] rsp_error;
    logic        heapClock;
    logic [7:0]  heapAction;
    logic [1:0]  heapArray;
    logic [0:0]  heapIndex;
    logic [11:0] heapIn;
    logic [11:0] heapOut;
    logic [31:0] heapError;
    logic [31:0] op_count;
    logic        err_seen;
    logic [31:0] err_code;
    logic [31:0] err_op;

    int n_total;
    int n_bad;

    heap_requester u_dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_action (req_action),
        .req_array  (req_array),
        .req_index  (req_index),
        .req_in     (req_in),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_out    (rsp_out),
        .rsp_error  (rsp_error),
        .heapClock  (heapClock),
        .heapAction (heapAction),
        .heapArray  (heapArray),
        .heapIndex  (heapIndex),
        .heapIn     (heapIn),
        .heapOut    (heapOut),
        .heapError  (heapError),
        .op_count   (op_count),
        .err_seen   (err_seen),
        .err_code   (err_code),
        .err_op     (err_op)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock edge, then settle outputs before sampling.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic drive_req(input logic [7:0] act, input logic [1:0] arr, input logic [11:0] din);
        req_valid  = 1'b1;
        req_action = act;
        req_array  = arr;
        req_index  = 1'b0;
        req_in     = din;
    endtask

    initial begin
        n_total    = 0;
        n_bad      = 0;
        reset      = 1'b0;
        req_valid  = 1'b0;
        req_action = 8'd0;
        req_array  = 2'd0;
        req_index  = 1'b0;
        req_in     = 12'd0;
        rsp_ready  = 1'b0;
        heapOut    = 12'd0;
        heapError  = 32'd0;
        #2;

        // Reset state
        do_reset();
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_out", {20'd0, rsp_out}, 32'd0);
        chk("rst_rsp_error", rsp_error, 32'd0);
        chk("rst_heapClock", {31'd0, heapClock}, 32'd0);
        chk("rst_heapAction", {24'd0, heapAction}, 32'd0);
        chk("rst_op_count", op_count, 32'd0);
        chk("rst_err_seen", {31'd0, err_seen}, 32'd0);

        // Size request: action 4, array 1, memory answers 3
        heapOut   = 12'h003;
        rsp_ready = 1'b1;
        drive_req(8'd4, 2'd1, 12'd0);
        step();                                  // edge 0
        req_valid = 1'b0;
        chk("size_e0_ready", {31'd0, req_ready}, 32'd0);
        chk("size_e0_action", {24'd0, heapAction}, 32'd4);
        chk("size_e0_array", {30'd0, heapArray}, 32'd1);
        step();                                  // edge 1
        chk("size_e1_hclk", {31'd0, heapClock}, 32'd0);
        step();                                  // edge 2
        chk("size_e2_hclk", {31'd0, heapClock}, 32'd1);
        chk("size_e2_valid", {31'd0, rsp_valid}, 32'd0);
        step();                                  // edge 3
        chk("size_e3_valid", {31'd0, rsp_valid}, 32'd1);
        chk("size_e3_out", {20'd0, rsp_out}, 32'd3);
        chk("size_e3_err", rsp_error, 32'd0);
        step();                                  // edge 4: handshake
        chk("size_op_count", op_count, 32'd1);
        chk("size_ready_back", {31'd0, req_ready}, 32'd1);

        // Back-to-back Greater (action 9, in 5), req_valid held
        do_reset();
        heapOut = 12'h001;
        drive_req(8'd9, 2'd0, 12'd5);
        step();                                  // edge 0
        chk("gt1_in", {20'd0, heapIn}, 32'd5);
        step();
        step();                                  // edge 2
        chk("gt1_hclk", {31'd0, heapClock}, 32'd1);
        step();                                  // edge 3
        chk("gt1_valid", {31'd0, rsp_valid}, 32'd1);
        step();                                  // edge 4: handshake
        chk("gt1_op_count", op_count, 32'd1);
        chk("gt1_ready_after_hs", {31'd0, req_ready}, 32'd1);
        step();                                  // edge 5: second accept
        req_valid = 1'b0;
        chk("gt2_accepted", {31'd0, req_ready}, 32'd0);
        step();                                  // edge 6
        chk("gt2_hclk_hold", {31'd0, heapClock}, 32'd1);
        step();                                  // edge 7
        chk("gt2_hclk", {31'd0, heapClock}, 32'd0);
        step();                                  // edge 8
        chk("gt2_valid", {31'd0, rsp_valid}, 32'd1);
        step();                                  // edge 9
        chk("gt2_op_count", op_count, 32'd2);

        // Backpressure: rsp_ready low for 10 cycles in RESPOND
        rsp_ready = 1'b0;
        heapOut   = 12'hABC;
        drive_req(8'd4, 2'd2, 12'd0);
        step();
        req_action = 8'd5;
        step();
        step();
        step();                                  // edge 3: RESPOND
        heapOut = 12'h000;
        for (int i = 0; i < 10; i++) begin
            chk("bp_valid", {31'd0, rsp_valid}, 32'd1);
            chk("bp_out", {20'd0, rsp_out}, 32'hABC);
            chk("bp_no_accept", {31'd0, req_ready}, 32'd0);
            chk("bp_op_count", op_count, 32'd2);
            step();
        end
        chk("bp_action_held", {24'd0, heapAction}, 32'd4);
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        step();
        chk("bp_op_count_done", op_count, 32'd3);
        chk("bp_valid_done", {31'd0, rsp_valid}, 32'd0);

        // Illegal actions 0 and 31
        do_reset();
        drive_req(8'd0, 2'd0, 12'd0);
        step();                                  // edge 0
        req_valid = 1'b0;
        chk("ill0_e0_valid", {31'd0, rsp_valid}, 32'd0);
        step();                                  // edge 1
        chk("ill0_e1_valid", {31'd0, rsp_valid}, 32'd1);
        chk("ill0_err", rsp_error, 32'd1);
        chk("ill0_out", {20'd0, rsp_out}, 32'd0);
        chk("ill0_hclk", {31'd0, heapClock}, 32'd0);
        step();                                  // handshake
        chk("ill0_err_seen", {31'd0, err_seen}, 32'd1);
        chk("ill0_err_code", err_code, 32'd1);
        chk("ill0_err_op", err_op, 32'd0);
        chk("ill0_op_count", op_count, 32'd1);
        drive_req(8'd31, 2'd3, 12'd7);
        step();                                  // edge 0
        req_valid = 1'b0;
        chk("ill31_action", {24'd0, heapAction}, 32'd0);
        chk("ill31_e0_valid", {31'd0, rsp_valid}, 32'd0);
        step();                                  // edge 1
        chk("ill31_e1_valid", {31'd0, rsp_valid}, 32'd1);
        chk("ill31_err", rsp_error, 32'd1);
        step();
        chk("ill31_err_code", err_code, 32'd1);
        chk("ill31_err_op", err_op, 32'd0);
        chk("ill31_op_count", op_count, 32'd2);
        chk("ill31_hclk", {31'd0, heapClock}, 32'd0);

        // Legal op interrupted by reset while in SETTLE with heapClock=1
        do_reset();
        rsp_ready = 1'b0;
        drive_req(8'd4, 2'd1, 12'd0);
        step();
        req_valid = 1'b0;
        step();
        step();                                  // edge 2: toggled, in SETTLE
        chk("rs_hclk_pre", {31'd0, heapClock}, 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rs_hclk", {31'd0, heapClock}, 32'd0);
        chk("rs_action", {24'd0, heapAction}, 32'd0);
        chk("rs_valid", {31'd0, rsp_valid}, 32'd0);
        step();
        step();
        chk("rs_valid_later", {31'd0, rsp_valid}, 32'd0);
        chk("rs_op_count", op_count, 32'd0);
        chk("rs_ready", {31'd0, req_ready}, 32'd1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
